// File: rtl/bit_parity_mod_tracker_if.sv
// bit_parity_mod_tracker_if: beat input and residue/status output bundle for the tracker
interface bit_parity_mod_tracker_if #(
    parameter int W = 1,
    parameter int M = 2,
    parameter int CNT_W = 16
);
    localparam int RW = ($clog2(M) < 1) ? 1 : $clog2(M);
    localparam int SO = M * M;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             clear;
    logic [RW-1:0]    ones_res;
    logic [RW-1:0]    zeros_res;
    logic [M-1:0]     ones_onehot;
    logic [M-1:0]     zeros_onehot;
    logic [SO-1:0]    state_onehot;
    logic             match;
    logic             match_pulse;
    logic [CNT_W-1:0] beat_cnt;
    modport master (
        output in_valid, in_data, clear,
        input  ones_res, zeros_res, ones_onehot, zeros_onehot, state_onehot, match, match_pulse, beat_cnt
    );
    modport slave (
        input  in_valid, in_data, clear,
        output ones_res, zeros_res, ones_onehot, zeros_onehot, state_onehot, match, match_pulse, beat_cnt
    );
endinterface

// File: rtl/bit_parity_mod_tracker.sv
// bit_parity_mod_tracker: running ones/zeros counts mod M with target match and saturating beat count
module bit_parity_mod_tracker #(
    parameter int W = 1,
    parameter int M = 2,
    parameter int ONES_TGT = 0,
    parameter int ZEROS_TGT = 0,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic reset,
    bit_parity_mod_tracker_if.slave bus
);
    localparam int RW = ($clog2(M) < 1) ? 1 : $clog2(M);
    localparam int SW = RW + 1;
    localparam int SO = M * M;
    if (W < 1 || M < 2 || ONES_TGT < 0 || ONES_TGT >= M || ZEROS_TGT < 0 || ZEROS_TGT >= M) begin : g_bad_params
        $error("bit_parity_mod_tracker: illegal W, M or target parameters");
    end
    logic [RW-1:0]    ones_q, zeros_q, ones_c, zeros_c, ones_n, zeros_n;
    logic [SW-1:0]    ones_s, zeros_s;
    logic [CNT_W-1:0] cnt_q;
    logic             pulse_q, match_c, match_n;
    int               p;
    // Each increment is pre-reduced below M, so the sum stays under 2M and one subtract suffices.
    always_comb begin
        p = 0;
        for (int i = 0; i < W; i++) p = p + int'(bus.in_data[i]);
        ones_c  = ({1'b0, ones_q} < SW'(M)) ? ones_q : '0;
        zeros_c = ({1'b0, zeros_q} < SW'(M)) ? zeros_q : '0;
        ones_s  = {1'b0, ones_c} + SW'(p % M);
        zeros_s = {1'b0, zeros_c} + SW'((W - p) % M);
        ones_n  = (ones_s >= SW'(M)) ? RW'(ones_s - SW'(M)) : RW'(ones_s);
        zeros_n = (zeros_s >= SW'(M)) ? RW'(zeros_s - SW'(M)) : RW'(zeros_s);
        match_c = ones_q == RW'(ONES_TGT) && zeros_q == RW'(ZEROS_TGT);
        match_n = ones_n == RW'(ONES_TGT) && zeros_n == RW'(ZEROS_TGT);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            ones_q  <= '0;
            zeros_q <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else if (bus.clear) begin
            ones_q  <= '0;
            zeros_q <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else if (bus.in_valid) begin
            ones_q  <= ones_n;
            zeros_q <= zeros_n;
            cnt_q   <= (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            pulse_q <= match_n && !match_c;
        end else begin
            pulse_q <= 1'b0;
        end
    end
    assign bus.ones_res     = ones_q;
    assign bus.zeros_res    = zeros_q;
    assign bus.ones_onehot  = M'(1) << ones_q;
    assign bus.zeros_onehot = M'(1) << zeros_q;
    assign bus.state_onehot = SO'(1) << (int'(ones_q) * M + int'(zeros_q));
    assign bus.match        = match_c;
    assign bus.match_pulse  = pulse_q;
    assign bus.beat_cnt     = cnt_q;
endmodule

// File: tb/tb_bit_parity_mod_tracker.sv
// tb_bit_parity_mod_tracker: directed checks of residues, one-hots, match strobe and beat count
module tb_bit_parity_mod_tracker;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;

    bit_parity_mod_tracker_if #(.W(1), .M(2), .CNT_W(16)) b0 ();
    bit_parity_mod_tracker_if #(.W(8), .M(3), .CNT_W(16)) b1 ();
    bit_parity_mod_tracker_if #(.W(1), .M(2), .CNT_W(4))  b2 ();
    bit_parity_mod_tracker_if #(.W(4), .M(2), .CNT_W(16)) b3 ();

    bit_parity_mod_tracker #(.W(1), .M(2), .ONES_TGT(0), .ZEROS_TGT(0), .CNT_W(16)) u0 (.clk(clk), .reset(reset), .bus(b0));
    bit_parity_mod_tracker #(.W(8), .M(3), .ONES_TGT(0), .ZEROS_TGT(0), .CNT_W(16)) u1 (.clk(clk), .reset(reset), .bus(b1));
    bit_parity_mod_tracker #(.W(1), .M(2), .ONES_TGT(0), .ZEROS_TGT(0), .CNT_W(4))  u2 (.clk(clk), .reset(reset), .bus(b2));
    bit_parity_mod_tracker #(.W(4), .M(2), .ONES_TGT(1), .ZEROS_TGT(1), .CNT_W(16)) u3 (.clk(clk), .reset(reset), .bus(b3));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        b0.in_valid = 1'b1; b0.clear = 1'b1; b0.in_data = 1'b1;
        b1.in_valid = 1'b1; b1.clear = 1'b0; b1.in_data = 8'hFF;
        b3.in_valid = 1'b1; b3.clear = 1'b0; b3.in_data = 4'h7;
        step();
        step();
        checks++; if ({b0.ones_res, b0.zeros_res} !== 2'b00) begin failures++; $display("FAIL reset_res got %b want 00", {b0.ones_res, b0.zeros_res}); end
        checks++; if ({b0.ones_onehot, b0.zeros_onehot} !== 4'b0101) begin failures++; $display("FAIL reset_onehot got %b want 0101", {b0.ones_onehot, b0.zeros_onehot}); end
        checks++; if (b0.state_onehot !== 4'b0001) begin failures++; $display("FAIL reset_state got %b want 0001", b0.state_onehot); end
        checks++; if ({b0.match, b0.match_pulse} !== 2'b10) begin failures++; $display("FAIL reset_match got %b want 10", {b0.match, b0.match_pulse}); end
        checks++; if (b0.beat_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got %0d want 0", b0.beat_cnt); end
        checks++; if ({b1.ones_res, b1.zeros_res, b1.beat_cnt} !== 20'd0) begin failures++; $display("FAIL reset_d1 got %h want 0", {b1.ones_res, b1.zeros_res, b1.beat_cnt}); end
        checks++; if ({b3.match, b3.match_pulse} !== 2'b00) begin failures++; $display("FAIL reset_tgt11_match got %b want 00", {b3.match, b3.match_pulse}); end
        b0.in_valid = 1'b0; b0.clear = 1'b0;
        b1.in_valid = 1'b0;
        b3.in_valid = 1'b0;
        reset = 1'b1;
        step();
    endtask

    task automatic test_parity();
        logic       dat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] st  [4] = '{4'b0100, 4'b1000, 4'b0100, 4'b0001};
        logic       pul [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            b0.in_valid = 1'b1; b0.in_data = dat[i];
            step();
            checks++; if (b0.state_onehot !== st[i]) begin failures++; $display("FAIL parity_state beat%0d got %b want %b", i, b0.state_onehot, st[i]); end
            checks++; if (b0.match_pulse !== pul[i]) begin failures++; $display("FAIL parity_pulse beat%0d got %b want %b", i, b0.match_pulse, pul[i]); end
            checks++; if (b0.beat_cnt !== 16'(i + 1)) begin failures++; $display("FAIL parity_cnt beat%0d got %0d want %0d", i, b0.beat_cnt, i + 1); end
        end
        b0.in_valid = 1'b0;
        step();
        checks++; if ({b0.match, b0.match_pulse} !== 2'b10) begin failures++; $display("FAIL parity_pulse_drop got %b want 10", {b0.match, b0.match_pulse}); end
    endtask

    task automatic test_hold_clear();
        b0.in_valid = 1'b1; b0.in_data = 1'b1;
        step();
        b0.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b0.in_data = 1'($urandom);
            step();
            checks++; if ({b0.ones_res, b0.zeros_res, b0.match, b0.match_pulse} !== 4'b1000) begin failures++; $display("FAIL hold_res cyc%0d got %b want 1000", i, {b0.ones_res, b0.zeros_res, b0.match, b0.match_pulse}); end
            checks++; if ({b0.state_onehot, b0.beat_cnt} !== {4'b0100, 16'd5}) begin failures++; $display("FAIL hold_state cyc%0d got %h want 40005", i, {b0.state_onehot, b0.beat_cnt}); end
        end
        b0.clear = 1'b1; b0.in_valid = 1'b1; b0.in_data = 1'b1;
        step();
        checks++; if ({b0.ones_res, b0.zeros_res, b0.match, b0.match_pulse} !== 4'b0010) begin failures++; $display("FAIL clear_res got %b want 0010", {b0.ones_res, b0.zeros_res, b0.match, b0.match_pulse}); end
        checks++; if (b0.beat_cnt !== 16'd0) begin failures++; $display("FAIL clear_cnt got %0d want 0", b0.beat_cnt); end
        b0.clear = 1'b0; b0.in_valid = 1'b0;
    endtask

    task automatic test_modulus();
        logic [7:0] dat [3] = '{8'hFF, 8'h0F, 8'h00};
        logic [1:0] eo  [3] = '{2'd2, 2'd0, 2'd0};
        logic [1:0] ez  [3] = '{2'd0, 2'd1, 2'd0};
        logic [8:0] st  [3] = '{9'h040, 9'h002, 9'h001};
        logic       pul [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            b1.in_valid = 1'b1; b1.in_data = dat[i];
            step();
            checks++; if ({b1.ones_res, b1.zeros_res} !== {eo[i], ez[i]}) begin failures++; $display("FAIL mod3_res beat%0d got %b want %b", i, {b1.ones_res, b1.zeros_res}, {eo[i], ez[i]}); end
            checks++; if (b1.state_onehot !== st[i]) begin failures++; $display("FAIL mod3_state beat%0d got %b want %b", i, b1.state_onehot, st[i]); end
            checks++; if ({b1.match_pulse, b1.beat_cnt} !== {pul[i], 16'(i + 1)}) begin failures++; $display("FAIL mod3_pulse_cnt beat%0d got %h want %h", i, {b1.match_pulse, b1.beat_cnt}, {pul[i], 16'(i + 1)}); end
        end
        b1.in_valid = 1'b0;
    endtask

    task automatic test_midstream_reset();
        b1.in_valid = 1'b1; b1.in_data = 8'hFF;
        step();
        checks++; if ({b1.ones_res, b1.zeros_res, b1.beat_cnt} !== {2'd2, 2'd0, 16'd4}) begin failures++; $display("FAIL mid_pre got %h want %h", {b1.ones_res, b1.zeros_res, b1.beat_cnt}, {2'd2, 2'd0, 16'd4}); end
        reset = 1'b0; b1.clear = 1'b1; b1.in_data = 8'h0F;
        step();
        checks++; if ({b1.ones_res, b1.zeros_res, b1.beat_cnt, b1.match_pulse, b1.match} !== {20'd0, 2'b01}) begin failures++; $display("FAIL mid_reset got %h want 1", {b1.ones_res, b1.zeros_res, b1.beat_cnt, b1.match_pulse, b1.match}); end
        checks++; if ({b1.state_onehot, b1.ones_onehot, b1.zeros_onehot} !== {9'h001, 3'b001, 3'b001}) begin failures++; $display("FAIL mid_reset_onehot got %b want 000000001001001", {b1.state_onehot, b1.ones_onehot, b1.zeros_onehot}); end
        reset = 1'b1; b1.clear = 1'b0; b1.in_data = 8'h01;
        step();
        checks++; if ({b1.ones_res, b1.zeros_res, b1.beat_cnt} !== {2'd1, 2'd1, 16'd1}) begin failures++; $display("FAIL mid_restart got %h want %h", {b1.ones_res, b1.zeros_res, b1.beat_cnt}, {2'd1, 2'd1, 16'd1}); end
        checks++; if (b1.state_onehot !== 9'h010) begin failures++; $display("FAIL mid_restart_state got %b want 000010000", b1.state_onehot); end
        b1.in_valid = 1'b0;
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 20; i++) begin
            b2.in_valid = 1'b1; b2.in_data = 1'(i);
            step();
            checks++; if (b2.beat_cnt !== 4'((i < 15) ? i : 15)) begin failures++; $display("FAIL sat_cnt beat%0d got %0d want %0d", i, b2.beat_cnt, (i < 15) ? i : 15); end
        end
        b2.in_valid = 1'b0;
    endtask

    task automatic test_target();
        logic [3:0] dat [5] = '{4'h7, 4'hC, 4'hF, 4'h1, 4'h1};
        logic [1:0] res [5] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b11};
        logic       mat [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       pul [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            b3.in_valid = 1'b1; b3.in_data = dat[i];
            step();
            checks++; if ({b3.ones_res, b3.zeros_res} !== res[i]) begin failures++; $display("FAIL tgt_res beat%0d got %b want %b", i, {b3.ones_res, b3.zeros_res}, res[i]); end
            checks++; if ({b3.match, b3.match_pulse} !== {mat[i], pul[i]}) begin failures++; $display("FAIL tgt_match beat%0d got %b want %b", i, {b3.match, b3.match_pulse}, {mat[i], pul[i]}); end
        end
        b3.in_valid = 1'b0;
        step();
        checks++; if (b3.match_pulse !== 1'b0) begin failures++; $display("FAIL tgt_pulse_drop got %b want 0", b3.match_pulse); end
    endtask

    initial begin
        b0.in_valid = 1'b0; b0.clear = 1'b0; b0.in_data = '0;
        b1.in_valid = 1'b0; b1.clear = 1'b0; b1.in_data = '0;
        b2.in_valid = 1'b0; b2.clear = 1'b0; b2.in_data = '0;
        b3.in_valid = 1'b0; b3.clear = 1'b0; b3.in_data = '0;
        test_reset();
        test_parity();
        test_hold_clear();
        test_modulus();
        test_midstream_reset();
        test_saturation();
        test_target();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
